bw_seq_multiplier: RTL and testbench
====================================

Name: bw_seq_multiplier

Overview:
- Parametrised, iterative Baugh-Wooley multiplier; successor to the fixed 4x4 combinational array.
- Multiplies two WIDTH-bit operands, signed (two's complement) or unsigned, selected per operation, into a 2*WIDTH-bit product.
- Adds one partial-product row per clock to save area, behind valid/ready handshakes on both sides.
- Sits between operand producers and the accumulator/datapath stages of the arithmetic unit.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the row counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- p  output  2*WIDTH  product.
- busy  output  1  high while in BUSY state.

Behaviour:
- Reset: rst_n low at a rising edge forces IDLE, in_ready=1, out_valid=0, busy=0, p=0, and clears the row counter and accumulator. It overrides everything, including mid-operation; an in-flight operation is discarded.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a, b and signed_mode;
  - load the accumulator with the correction constant: signed = 2^WIDTH + 2^(2*WIDTH-1); unsigned = 0;
  - set counter=0 and go to BUSY.
- BUSY: in_ready=0, busy=1. Each cycle, add row i=counter, shifted left by i, into the 2*WIDTH-bit accumulator (mod 2^(2*WIDTH)), then increment the counter.
  - Unsigned row i: a & {WIDTH{b[i]}}.
  - Signed row i<WIDTH-1: bits 0..WIDTH-2 are a[j]&b[i]; bit WIDTH-1 is ~(a[WIDTH-1]&b[i]).
  - Signed row WIDTH-1: bits 0..WIDTH-2 are ~(a[j]&b[WIDTH-1]); bit WIDTH-1 is a[WIDTH-1]&b[WIDTH-1].
  - After row WIDTH-1 is added, go to DONE.
- Latency: handshake at edge t; out_valid=1 from edge t+WIDTH. That is WIDTH BUSY cycles; out_valid is first seen in the cycle following edge t+WIDTH.
- DONE: out_valid=1, p=accumulator, in_ready=0.
  - p and out_valid are held stable while out_ready=0 (backpressure of any length).
  - On out_valid&&out_ready, go to IDLE; out_valid drops at that edge.
- No overlap: a new operation is accepted only from IDLE, so at least one idle cycle separates results.
- Changes on in_valid or the operand inputs while not in IDLE are ignored.
- p is registered; it holds the last product in IDLE until the next result or reset.
- Boundary cases:
  - the most-negative operands (signed -2^(WIDTH-1) squared) give +2^(2*WIDTH-2) with no overflow;
  - zero operands give 0 in both modes;
  - signed_mode is sampled only at acceptance.

Decomposition:
- Shared package bw_mul_pkg:
  - state enum (IDLE, BUSY, DONE);
  - function bw_corr(width, signed_mode) returning the correction constant;
  - WIDTH legality check constant.
- One natural sub-module: bw_pp_row, a combinational generator of partial-product row i (inputs a, b_bit, row_is_last, signed_mode; output WIDTH bits), reused by a future fully-unrolled array variant.

Test Plan:
- WIDTH=8, signed, a=0xFD(-3), b=0x05 -> p=0xFFF1 after exactly 8 BUSY cycles; out_valid first seen at edge t+8.
- WIDTH=8, signed, a=0x80, b=0x80 -> p=0x4000; a=0x7F, b=0x80 -> p=0xC080.
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> p=0xFE01; same bits in signed mode -> p=0x0001.
- Backpressure: out_ready held low 5 cycles after DONE -> p and out_valid stable, in_ready=0 throughout; in_valid pulses ignored; out_ready=1 -> IDLE next edge.
- Reset mid-operation: rst_n low at BUSY counter=3 -> next edge IDLE, p=0, out_valid=0; the following operation (a=0x02, b=0x03, unsigned) -> p=0x0006.
- WIDTH=4 regression: all 256 signed and 256 unsigned operand pairs checked against a behavioural reference; also WIDTH=16 random (1000 ops, random handshake stalls).

Source files
------------

// File: rtl/bw_mul_pkg.sv
// Shared types and helpers for the iterative Baugh-Wooley multiplier family.
// Holds the controller state encoding, the legal width range and the signed correction constant.
package bw_mul_pkg;

  localparam int unsigned BW_MIN_WIDTH = 2;
  localparam int unsigned BW_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bw_state_e;

  function automatic bit bw_width_ok(input int unsigned width);
    return (width >= BW_MIN_WIDTH) && (width <= BW_MAX_WIDTH);
  endfunction

  // The complemented sign-row bits each leave a known offset; seeding the
  // accumulator with 2^W + 2^(2W-1) cancels it modulo 2^(2W).
  function automatic logic [63:0] bw_corr(input int unsigned width, input logic signed_mode);
    logic [63:0] c;
    c = '0;
    if (signed_mode) c = (64'd1 << width) + (64'd1 << (2 * width - 1));
    return c;
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// Combinational Baugh-Wooley partial-product row generator.
// Produces row i of the array; the caller applies the shift by i.
module bw_pp_row
  import bw_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
  input  logic             row_is_last,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] row
);

  logic [WIDTH-1:0] and_row;

  assign and_row = a & {WIDTH{b_bit}};

  // NOTE: every output of an always_comb gets a value before any branch, so no latch can form.
  always_comb begin
    row = and_row;
    if (signed_mode) begin
      if (row_is_last) row[WIDTH-2:0] = ~and_row[WIDTH-2:0];
      else             row[WIDTH-1]   = ~and_row[WIDTH-1];
    end
  end

endmodule

// File: rtl/bw_seq_multiplier.sv
// Iterative Baugh-Wooley multiplier: one partial-product row per clock,
// valid/ready on both sides, signed or unsigned chosen per operation.
module bw_seq_multiplier
  import bw_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [2*WIDTH-1:0] CORR_SIGNED = (2 * WIDTH)'(bw_corr(WIDTH, 1'b1));

  if (!bw_width_ok(WIDTH)) begin : g_width_check
    $error("bw_seq_multiplier: WIDTH must lie in 2..32");
  end

  bw_state_e          state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sm_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, p_q;
  logic [WIDTH-1:0]   row;
  logic [2*WIDTH-1:0] row_sh, acc_sum;
  logic               accept, last_row;

  assign accept   = in_valid && in_ready;
  assign last_row = (cnt_q == CNT_W'(WIDTH - 1));

  bw_pp_row #(.WIDTH(WIDTH)) u_row (
    .a           (a_q),
    .b_bit       (b_q[cnt_q]),
    .row_is_last (last_row),
    .signed_mode (sm_q),
    .row         (row)
  );

  assign row_sh  = {{WIDTH{1'b0}}, row} << cnt_q;
  assign acc_sum = acc_q + row_sh;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_row) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are only read in BUSY, always after a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      sm_q <= signed_mode;
    end
  end

  // p is captured only when the last row lands, so it holds the previous result through BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      p_q   <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      acc_q <= signed_mode ? CORR_SIGNED : '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= acc_sum;
      if (last_row) p_q <= acc_sum;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Self-checking bench for bw_seq_multiplier at WIDTH 4, 8 and 16: directed table,
// backpressure and mid-operation reset, exhaustive WIDTH=4, random WIDTH=16.
module tb_bw_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv4, ir4, sm4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, sm16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  bw_seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4));
  bw_seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8));
  bw_seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .p(p16), .busy(busy16));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands interpreted per mode, kept to 2W bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic s);
    longint m, x, y, half, prod;
    logic [63:0] mask;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    x    = longint'({32'd0, av}) & m;
    y    = longint'({32'd0, bv}) & m;
    if (s) begin
      if (x >= half) x = x - (longint'(1) << w);
      if (y >= half) y = y - (longint'(1) << w);
    end
    prod = x * y;
    mask = (2 * w >= 64) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(prod) & mask;
  endfunction

  task automatic drive_in(input int w, input logic v, input logic [31:0] av,
                          input logic [31:0] bv, input logic s);
    case (w)
      4:       begin iv4  = v; a4  = av[3:0];  b4  = bv[3:0];  sm4  = s; end
      8:       begin iv8  = v; a8  = av[7:0];  b8  = bv[7:0];  sm8  = s; end
      default: begin iv16 = v; a16 = av[15:0]; b16 = bv[15:0]; sm16 = s; end
    endcase
  endtask

  task automatic drive_junk(input int w);
    drive_in(w, 1'($urandom), $urandom, $urandom, 1'($urandom));
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      4:       or4  = v;
      8:       or8  = v;
      default: or16 = v;
    endcase
  endtask

  function automatic logic get_ir(input int w);
    case (w) 4: return ir4; 8: return ir8; default: return ir16; endcase
  endfunction
  function automatic logic get_ov(input int w);
    case (w) 4: return ov4; 8: return ov8; default: return ov16; endcase
  endfunction
  function automatic logic get_busy(input int w);
    case (w) 4: return busy4; 8: return busy8; default: return busy16; endcase
  endfunction
  function automatic logic [63:0] get_p(input int w);
    case (w) 4: return 64'(p4); 8: return 64'(p8); default: return 64'(p16); endcase
  endfunction

  // One full transaction; inputs change #1 after an edge, outputs are read there too.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input int gap, input int stall,
                        input logic [63:0] exp, input string tag);
    int k;
    for (int i = 0; i < gap; i++) begin
      drive_in(w, 1'b0, $urandom, $urandom, 1'($urandom));
      @(posedge clk); #1;
    end
    k = 0;
    while (!get_ir(w) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " in_ready before"}, 64'(get_ir(w)), 64'd1);
    drive_in(w, 1'b1, av, bv, s);
    @(posedge clk); #1;
    drive_junk(w);
    check({tag, " busy"}, 64'({get_busy(w), get_ir(w)}), 64'b10);
    k = 0;
    while (!get_ov(w) && k < 4 * w) begin
      @(posedge clk); #1;
      drive_junk(w);
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(w));
    check({tag, " product"}, get_p(w), exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      drive_junk(w);
      check({tag, " stall hold"}, {get_p(w)[61:0], get_ov(w), get_ir(w)}, {exp[61:0], 2'b10});
    end
    drive_in(w, 1'b0, $urandom, $urandom, 1'($urandom));
    set_or(w, 1'b1);
    @(posedge clk); #1;
    set_or(w, 1'b0);
    check({tag, " release"}, {get_p(w)[61:0], get_ov(w), get_ir(w)}, {exp[61:0], 2'b01});
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
    string       name;
  } vec_t;

  vec_t tbl[12];
  int   ws[3] = '{4, 8, 16};

  initial begin
    tbl[0]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_neg3x5"};
    tbl[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, "s_minxmin"};
    tbl[2]  = '{8'h7F, 8'h80, 1'b1, 16'hC080, "s_maxxmin"};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ffxff"};
    tbl[4]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1"};
    tbl[5]  = '{8'h00, 8'h00, 1'b0, 16'h0000, "u_zero"};
    tbl[6]  = '{8'h00, 8'h5A, 1'b1, 16'h0000, "s_zero"};
    tbl[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_maxxmax"};
    tbl[8]  = '{8'h80, 8'h01, 1'b1, 16'hFF80, "s_minx1"};
    tbl[9]  = '{8'h80, 8'hFF, 1'b1, 16'h0080, "s_minxm1"};
    tbl[10] = '{8'h12, 8'h34, 1'b0, 16'h03A8, "u_12x34"};
    tbl[11] = '{8'h80, 8'hFF, 1'b0, 16'h7F80, "u_80xff"};

    rst_n = 1'b0;
    foreach (ws[i]) begin
      drive_in(ws[i], 1'b0, 32'd0, 32'd0, 1'b0);
      set_or(ws[i], 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    foreach (ws[i]) begin
      check($sformatf("reset w%0d flags", ws[i]),
            64'({get_ir(ws[i]), get_busy(ws[i]), get_ov(ws[i])}), 64'b100);
      check($sformatf("reset w%0d p", ws[i]), get_p(ws[i]), 64'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(8, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].s, i % 2, 0, 64'(tbl[i].p), tbl[i].name);

    run_op(8, 32'hFD, 32'h05, 1'b1, 1, 5, 64'hFFF1, "backpressure");

    // Reset with the row counter at 3 must discard the operation and clear p.
    drive_in(8, 1'b1, 32'h11, 32'h22, 1'b0);
    @(posedge clk); #1;
    drive_in(8, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst busy before", 64'(get_busy(8)), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst flags", 64'({ir8, busy8, ov8}), 64'b100);
    check("mid_rst p", 64'(p8), 64'd0);
    rst_n = 1'b1;
    run_op(8, 32'h02, 32'h03, 1'b0, 1, 0, 64'h0006, "after_rst");

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run_op(4, 32'(x), 32'(y), 1'(s), 0, 0, ref_mul(4, 32'(x), 32'(y), 1'(s)),
                 $sformatf("w4 s%0d %0d*%0d", s, x, y));

    for (int n = 0; n < 1000; n++) begin
      logic [31:0] av, bv;
      logic        sv;
      av = $urandom & 32'hFFFF;
      bv = $urandom & 32'hFFFF;
      sv = 1'($urandom);
      run_op(16, av, bv, sv, $urandom_range(0, 2), $urandom_range(0, 3),
             ref_mul(16, av, bv, sv), $sformatf("w16 #%0d s%0d %h*%h", n, sv, av[15:0], bv[15:0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
